// File: rtl/pci_image_xlat_regs.sv
// PCI image register file with one-cycle address decode/translate pipeline
// and transaction error capture.
module pci_image_xlat_regs #(
  parameter int unsigned NUM_IMG  = 6,
  parameter int unsigned AM_LSB   = 12,
  parameter logic [11:0] ERR_BASE = 12'h160
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        reg_req_i,
  input  logic        reg_we_i,
  input  logic [11:0] reg_addr_i,
  input  logic [31:0] reg_wdata_i,
  input  logic [3:0]  reg_be_i,
  output logic        reg_ack_o,
  output logic        reg_err_o,
  output logic [31:0] reg_rdata_o,
  input  logic        xl_valid_i,
  input  logic [31:0] xl_addr_i,
  output logic        xl_valid_o,
  output logic        xl_hit_o,
  output logic [2:0]  xl_img_o,
  output logic [31:0] xl_addr_o,
  input  logic        err_log_i,
  input  logic [31:0] err_addr_i,
  input  logic [31:0] err_data_i,
  output logic        err_pend_o
);

  localparam int unsigned DW = 32;
  localparam int unsigned WW = 10;
  localparam int unsigned IW = 3;
  localparam logic [DW-1:0] IMPL_MASK  = {DW{1'b1}} << AM_LSB;
  localparam logic [WW-1:0] W_ERR_CS   = ERR_BASE[11:2];
  localparam logic [WW-1:0] W_ERR_ADDR = W_ERR_CS + WW'(1);
  localparam logic [WW-1:0] W_ERR_DATA = W_ERR_CS + WW'(2);

  typedef enum logic {S_IDLE = 1'b0, S_ACK = 1'b1} state_t;

  function automatic logic [DW-1:0] be_merge(input logic [DW-1:0] old_v,
                                             input logic [DW-1:0] new_v,
                                             input logic [3:0]    be);
    logic [DW-1:0] res;
    for (int b = 0; b < 4; b++) res[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return res;
  endfunction

  function automatic logic is_err_word(input logic [WW-1:0] w);
    return (w == W_ERR_CS) || (w == W_ERR_ADDR) || (w == W_ERR_DATA);
  endfunction

  // Word address w selects image n (error registers take precedence on overlap)
  function automatic logic img_sel(input logic [WW-1:0] w, input int n);
    return (w[9:6] == 4'h1) && (w[5:2] == 4'(n)) && !is_err_word(w);
  endfunction

  state_t           r_state, w_state_nxt;
  logic             w_accept, w_commit;
  logic [WW-1:0]    w_req_w;
  logic [DW-1:0]    w_rdata;
  logic             w_unmapped;

  logic             r_ack, r_reg_err, r_we, r_unmapped;
  logic [WW-1:0]    r_addr;
  logic [DW-1:0]    r_wdata, r_rdata;
  logic [3:0]       r_be;

  logic [2:0]       r_ctrl [NUM_IMG];
  logic [DW-1:0]    r_ba   [NUM_IMG];
  logic [DW-1:0]    r_am   [NUM_IMG];
  logic [DW-1:0]    r_ta   [NUM_IMG];

  logic             r_err_valid, r_err_ovf;
  logic [DW-1:0]    r_err_addr, r_err_data;
  logic             w_cs_wr, w_clr_valid, w_clr_ovf, w_valid_eff;

  logic             w_hit;
  logic [IW-1:0]    w_img;
  logic [DW-1:0]    w_xaddr;
  logic             r_xl_valid, r_xl_hit;
  logic [IW-1:0]    r_xl_img;
  logic [DW-1:0]    r_xl_addr;

  logic             w_unused;

  assign w_req_w  = reg_addr_i[11:2];
  assign w_unused = ^reg_addr_i[1:0];

  // Access FSM state register
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Access FSM: accept in IDLE, complete (and commit writes) in ACK
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (reg_req_i) begin
          w_state_nxt = S_ACK;
          w_accept    = 1'b1;
        end
      end
      S_ACK: begin
        w_state_nxt = S_IDLE;
        w_commit    = r_we && !r_unmapped;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Read mux and address decode for the presented request
  always_comb begin
    w_rdata    = '0;
    w_unmapped = 1'b1;
    if (w_req_w == W_ERR_CS) begin
      w_rdata    = {30'd0, r_err_ovf, r_err_valid};
      w_unmapped = 1'b0;
    end else if (w_req_w == W_ERR_ADDR) begin
      w_rdata    = r_err_addr;
      w_unmapped = 1'b0;
    end else if (w_req_w == W_ERR_DATA) begin
      w_rdata    = r_err_data;
      w_unmapped = 1'b0;
    end else begin
      for (int n = 0; n < NUM_IMG; n++) begin
        if (img_sel(w_req_w, n)) begin
          w_unmapped = 1'b0;
          case (w_req_w[1:0])
            2'd0:    w_rdata = {29'd0, r_ctrl[n]};
            2'd1:    w_rdata = r_ba[n];
            2'd2:    w_rdata = r_am[n];
            default: w_rdata = r_ta[n];
          endcase
        end
      end
    end
  end

  // Latch the accepted request and produce the registered response
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_ack      <= 1'b0;
      r_reg_err  <= 1'b0;
      r_rdata    <= '0;
      r_we       <= 1'b0;
      r_unmapped <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
    end else begin
      r_ack     <= w_accept;
      r_reg_err <= w_accept && w_unmapped;
      if (w_accept) begin
        r_rdata    <= w_rdata;
        r_we       <= reg_we_i;
        r_unmapped <= w_unmapped;
        r_addr     <= w_req_w;
        r_wdata    <= reg_wdata_i;
        r_be       <= reg_be_i;
      end
    end
  end

  // Image registers, written on the ACK cycle with byte merge
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      for (int n = 0; n < NUM_IMG; n++) begin
        r_ctrl[n] <= '0;
        r_ba[n]   <= '0;
        r_am[n]   <= '0;
        r_ta[n]   <= '0;
      end
    end else begin
      for (int n = 0; n < NUM_IMG; n++) begin
        if (w_commit && img_sel(r_addr, n)) begin
          case (r_addr[1:0])
            2'd0:    r_ctrl[n] <= 3'(be_merge({29'd0, r_ctrl[n]}, r_wdata, r_be));
            2'd1:    r_ba[n]   <= be_merge(r_ba[n], r_wdata, r_be) & IMPL_MASK;
            2'd2:    r_am[n]   <= be_merge(r_am[n], r_wdata, r_be) & IMPL_MASK;
            default: r_ta[n]   <= be_merge(r_ta[n], r_wdata, r_be) & IMPL_MASK;
          endcase
        end
      end
    end
  end

  // Clear-before-capture: a W1C and a new error in the same cycle keep the new error
  assign w_cs_wr     = w_commit && (r_addr == W_ERR_CS) && r_be[0];
  assign w_clr_valid = w_cs_wr && r_wdata[0];
  assign w_clr_ovf   = w_cs_wr && r_wdata[1];
  assign w_valid_eff = r_err_valid && !w_clr_valid;

  // Error capture with sticky overflow
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_err_valid <= 1'b0;
      r_err_ovf   <= 1'b0;
      r_err_addr  <= '0;
      r_err_data  <= '0;
    end else begin
      r_err_valid <= w_valid_eff || err_log_i;
      r_err_ovf   <= (r_err_ovf && !w_clr_ovf) || (err_log_i && w_valid_eff);
      if (err_log_i && !w_valid_eff) begin
        r_err_addr <= err_addr_i;
        r_err_data <= err_data_i;
      end
    end
  end

  // Image match with lowest-index priority and optional translation
  always_comb begin
    w_hit   = 1'b0;
    w_img   = '0;
    w_xaddr = xl_addr_i;
    for (int n = 0; n < NUM_IMG; n++) begin
      if (!w_hit && r_ctrl[n][0] && (r_am[n] != '0) &&
          (((xl_addr_i ^ r_ba[n]) & r_am[n]) == '0)) begin
        w_hit = 1'b1;
        w_img = IW'(n);
        if (r_ctrl[n][1]) w_xaddr = (xl_addr_i & ~r_am[n]) | (r_ta[n] & r_am[n]);
      end
    end
  end

  // Translation result register; results hold while no address is presented
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_xl_valid <= 1'b0;
      r_xl_hit   <= 1'b0;
      r_xl_img   <= '0;
      r_xl_addr  <= '0;
    end else begin
      r_xl_valid <= xl_valid_i;
      if (xl_valid_i) begin
        r_xl_hit  <= w_hit;
        r_xl_img  <= w_img;
        r_xl_addr <= w_xaddr;
      end
    end
  end

  assign reg_ack_o   = r_ack;
  assign reg_err_o   = r_reg_err;
  assign reg_rdata_o = r_rdata;
  assign xl_valid_o  = r_xl_valid;
  assign xl_hit_o    = r_xl_hit;
  assign xl_img_o    = r_xl_img;
  assign xl_addr_o   = r_xl_addr;
  assign err_pend_o  = r_err_valid;

endmodule

// File: tb/tb_pci_image_xlat_regs.sv
// Directed plus randomized bench for pci_image_xlat_regs against a behavioural model.
module tb_pci_image_xlat_regs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        reg_req = 1'b0, reg_we = 1'b0;
  logic [11:0] reg_addr = '0;
  logic [31:0] reg_wdata = '0;
  logic [3:0]  reg_be = '0;
  logic        xl_valid = 1'b0;
  logic [31:0] xl_addr = '0;
  logic        err_log = 1'b0;
  logic [31:0] err_addr = '0, err_data = '0;

  logic        ack6, err6, xv6, hit6, pend6;
  logic [31:0] rd6, xa6;
  logic [2:0]  img6;
  logic        ack2, err2, xv2, hit2, pend2;
  logic [31:0] rd2, xa2;
  logic [2:0]  img2;

  always #5 clk = ~clk;

  pci_image_xlat_regs #(.NUM_IMG(6)) u_dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .reg_req_i(reg_req), .reg_we_i(reg_we), .reg_addr_i(reg_addr),
    .reg_wdata_i(reg_wdata), .reg_be_i(reg_be),
    .reg_ack_o(ack6), .reg_err_o(err6), .reg_rdata_o(rd6),
    .xl_valid_i(xl_valid), .xl_addr_i(xl_addr),
    .xl_valid_o(xv6), .xl_hit_o(hit6), .xl_img_o(img6), .xl_addr_o(xa6),
    .err_log_i(err_log), .err_addr_i(err_addr), .err_data_i(err_data),
    .err_pend_o(pend6));

  pci_image_xlat_regs #(.NUM_IMG(2)) u_dut2 (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .reg_req_i(reg_req), .reg_we_i(reg_we), .reg_addr_i(reg_addr),
    .reg_wdata_i(reg_wdata), .reg_be_i(reg_be),
    .reg_ack_o(ack2), .reg_err_o(err2), .reg_rdata_o(rd2),
    .xl_valid_i(xl_valid), .xl_addr_i(xl_addr),
    .xl_valid_o(xv2), .xl_hit_o(hit2), .xl_img_o(img2), .xl_addr_o(xa2),
    .err_log_i(err_log), .err_addr_i(err_addr), .err_data_i(err_data),
    .err_pend_o(pend2));

  int n_vec = 0;
  int n_bad = 0;

  // Behavioural model of the six-image register file
  logic [31:0] m_ctrl [6];
  logic [31:0] m_ba   [6];
  logic [31:0] m_am   [6];
  logic [31:0] m_ta   [6];
  logic        m_ev = 1'b0, m_eo = 1'b0;
  logic [31:0] m_ea = '0, m_ed = '0;
  localparam logic [31:0 ] IMPL = 32'hFFFF_F000;

  // Expected translation outputs of the most recently presented cycle
  logic        exp_v = 1'b0, exp_hit = 1'b0;
  logic [2:0]  exp_img = '0;
  logic [31:0] exp_addr = '0;
  logic        last_err2;
  logic [31:0] last_rd2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_vec++;
    assert (got === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, expv);
    end
  endtask

  function automatic logic exp_err(input logic [11:0] a, input int nimg);
    if (a >= 12'h160 && a <= 12'h16B) return 1'b0;
    if (a[11:8] == 4'h1 && int'(a[7:4]) < nimg) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    int i;
    i = int'(a[7:4]);
    if (exp_err(a, 6)) return 32'h0;
    if (a[11:4] == 8'h16) begin
      case (a[3:2])
        2'd0: return {30'd0, m_eo, m_ev};
        2'd1: return m_ea;
        default: return m_ed;
      endcase
    end
    case (a[3:2])
      2'd0: return m_ctrl[i];
      2'd1: return m_ba[i];
      2'd2: return m_am[i];
      default: return m_ta[i];
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? n[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  task automatic m_write(input logic [11:0] a, input logic [31:0] wd, input logic [3:0] be);
    int i;
    i = int'(a[7:4]);
    if (exp_err(a, 6)) return;
    if (a[11:4] == 8'h16) begin
      if (a[3:2] == 2'd0 && be[0]) begin
        if (wd[0]) m_ev = 1'b0;
        if (wd[1]) m_eo = 1'b0;
      end
      return;
    end
    case (a[3:2])
      2'd0: m_ctrl[i] = merge(m_ctrl[i], wd, be) & 32'h7;
      2'd1: m_ba[i]   = merge(m_ba[i], wd, be) & IMPL;
      2'd2: m_am[i]   = merge(m_am[i], wd, be) & IMPL;
      default: m_ta[i] = merge(m_ta[i], wd, be) & IMPL;
    endcase
  endtask

  task automatic m_error(input logic [31:0] a, input logic [31:0] d);
    if (m_ev) m_eo = 1'b1;
    else begin m_ev = 1'b1; m_ea = a; m_ed = d; end
  endtask

  // First enabled image whose window contains the address wins
  task automatic m_xlate(input logic [31:0] a, output logic h, output logic [2:0] img, output logic [31:0] xa);
    h = 1'b0; img = 3'd0; xa = a;
    for (int n = 0; n < 6; n++) begin
      if (!h && m_ctrl[n][0] && m_am[n] != 0 && (a & m_am[n]) == (m_ba[n] & m_am[n])) begin
        h = 1'b1;
        img = 3'(n);
        if (m_ctrl[n][1]) xa = (a & ~m_am[n]) | (m_ta[n] & m_am[n]);
      end
    end
  endtask

  task automatic xl_check();
    chk("xl_valid", 32'(xv6), 32'(exp_v));
    chk("xl_hit", 32'(hit6), 32'(exp_hit));
    chk("xl_img", 32'(img6), 32'(exp_img));
    chk("xl_addr", xa6, exp_addr);
  endtask

  task automatic xl_drive(input logic v, input logic [31:0] a);
    xl_valid = v;
    xl_addr = a;
    exp_v = v;
    if (v) m_xlate(a, exp_hit, exp_img, exp_addr);
  endtask

  task automatic xl_cycle(input logic v, input logic [31:0] a);
    @(negedge clk);
    xl_check();
    xl_drive(v, a);
  endtask

  task automatic reg_acc(input logic we, input logic [11:0] a, input logic [31:0] wd,
                         input logic [3:0] be, output logic [31:0] rd, output logic er);
    int cyc;
    @(negedge clk);
    reg_req = 1'b1; reg_we = we; reg_addr = a; reg_wdata = wd; reg_be = be;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (ack6 !== 1'b1 && cyc < 8);
    chk("ack_latency", 32'(cyc), 32'd1);
    rd = rd6; er = err6;
    last_rd2 = rd2; last_err2 = err2;
    reg_req = 1'b0;
    @(negedge clk);
    chk("ack_one_cycle", 32'(ack6), 32'd0);
  endtask

  task automatic reg_rd(input logic [11:0] a, output logic [31:0] rd);
    logic [31:0] e;
    logic er;
    e = m_read(a);
    reg_acc(1'b0, a, 32'h0, 4'h0, rd, er);
    chk($sformatf("rd_%h", a), rd, e);
    chk($sformatf("rd_err_%h", a), 32'(er), 32'(exp_err(a, 6)));
  endtask

  task automatic reg_wr(input logic [11:0] a, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] rd;
    logic er;
    reg_acc(1'b1, a, wd, be, rd, er);
    chk($sformatf("wr_err_%h", a), 32'(er), 32'(exp_err(a, 6)));
    m_write(a, wd, be);
  endtask

  task automatic err_event(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    err_log = 1'b1; err_addr = a; err_data = d;
    m_error(a, d);
    @(negedge clk);
    err_log = 1'b0;
    chk("err_pend", 32'(pend6), 32'(m_ev));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic [11:0] a;
    int cyc;
    logic pend_apply;
    int acks;

    for (int n = 0; n < 6; n++) begin
      m_ctrl[n] = 0; m_ba[n] = 0; m_am[n] = 0; m_ta[n] = 0;
    end

    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(ack6), 32'd0);
    chk("rst_err", 32'(err6), 32'd0);
    chk("rst_rdata", rd6, 32'd0);
    chk("rst_pend", 32'(pend6), 32'd0);
    xl_check();
    rst_n = 1'b1;

    // All registers read zero after reset
    for (int i = 0; i < 24; i++) reg_rd(12'(12'h100 + 4 * i), rd);
    for (int i = 0; i < 3; i++) reg_rd(12'(12'h160 + 4 * i), rd);

    // Image 0 programming and basic translation
    reg_wr(12'h104, 32'h8000_0FFF, 4'hF);
    reg_wr(12'h108, 32'hFFFF_0000, 4'hF);
    reg_wr(12'h10C, 32'h1234_0000, 4'hF);
    reg_wr(12'h100, 32'h0000_0003, 4'hF);
    reg_rd(12'h104, rd);
    chk("ba0_readback", rd, 32'h8000_0000);
    xl_cycle(1'b1, 32'h8000_ABCD);
    xl_cycle(1'b0, 32'h0);
    chk("tp_xlat_addr", xa6, 32'h1234_ABCD);
    reg_wr(12'h100, 32'h0000_0001, 4'hF);
    xl_cycle(1'b1, 32'h8000_ABCD);
    xl_cycle(1'b0, 32'h0);
    chk("tp_noat_addr", xa6, 32'h8000_ABCD);

    // Priority between overlapping images 1 and 3
    reg_wr(12'h114, 32'hA000_0000, 4'hF);
    reg_wr(12'h118, 32'hFF00_0000, 4'hF);
    reg_wr(12'h110, 32'h1, 4'hF);
    reg_wr(12'h134, 32'hA000_0000, 4'hF);
    reg_wr(12'h138, 32'hFFF0_0000, 4'hF);
    reg_wr(12'h130, 32'h1, 4'hF);
    xl_cycle(1'b1, 32'hA000_0010);
    xl_cycle(1'b0, 32'h0);
    chk("tp_prio_img", 32'(img6), 32'd1);
    reg_wr(12'h110, 32'h0, 4'h1);
    xl_cycle(1'b1, 32'hA000_0010);
    xl_cycle(1'b1, 32'h0000_0010);
    chk("tp_img3", 32'(img6), 32'd3);
    xl_cycle(1'b0, 32'h0);
    chk("tp_miss_hit", 32'(hit6), 32'd0);
    chk("tp_miss_addr", xa6, 32'h0000_0010);

    // Image range limits with two images, and unlisted offsets
    reg_wr(12'h120, 32'hCAFE_F00D, 4'hF);
    chk("n2_wr_err", 32'(last_err2), 32'd1);
    reg_rd(12'h120, rd);
    chk("n2_rd_err", 32'(last_err2), 32'd1);
    chk("n2_rd_zero", last_rd2, 32'd0);
    reg_rd(12'h114, rd);
    chk("n2_img1_ok", 32'(last_err2), 32'd0);
    reg_wr(12'h170, 32'hFFFF_FFFF, 4'hF);
    chk("n2_170_err", 32'(last_err2), 32'd1);
    reg_rd(12'h170, rd);
    reg_wr(12'h16C, 32'hFFFF_FFFF, 4'hF);
    reg_wr(12'h164, 32'hFFFF_FFFF, 4'hF);

    // Error capture, overflow, and clear concurrent with a new error
    err_event(32'hDEAD_0000, 32'h5A5A_5A5A);
    reg_rd(12'h164, rd);
    chk("err_addr_cap", rd, 32'hDEAD_0000);
    reg_rd(12'h168, rd);
    err_event(32'h1111_1111, 32'h2222_2222);
    reg_rd(12'h160, rd);
    chk("err_ovf", rd, 32'h3);
    reg_rd(12'h168, rd);
    chk("err_data_kept", rd, 32'h5A5A_5A5A);
    @(negedge clk);
    reg_req = 1'b1; reg_we = 1'b1; reg_addr = 12'h160; reg_wdata = 32'h3; reg_be = 4'hF;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (ack6 !== 1'b1 && cyc < 8);
    chk("w1c_ack_latency", 32'(cyc), 32'd1);
    reg_req = 1'b0;
    err_log = 1'b1; err_addr = 32'h3333_0000; err_data = 32'h4444_4444;
    m_write(12'h160, 32'h3, 4'hF);
    m_error(32'h3333_0000, 32'h4444_4444);
    @(negedge clk);
    err_log = 1'b0;
    chk("w1c_pend", 32'(pend6), 32'd1);
    reg_rd(12'h160, rd);
    chk("w1c_cs", rd, 32'h1);
    reg_rd(12'h164, rd);
    reg_rd(12'h168, rd);
    reg_wr(12'h160, 32'h1, 4'h1);
    chk("clr_pend", 32'(pend6), 32'd0);

    // Streaming translation across a CTRL0 rewrite
    reg_wr(12'h100, 32'h3, 4'hF);
    pend_apply = 1'b0;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      xl_check();
      if (pend_apply) begin m_write(12'h100, 32'h1, 4'hF); pend_apply = 1'b0; end
      if (i == 0) begin
        reg_req = 1'b1; reg_we = 1'b1; reg_addr = 12'h100; reg_wdata = 32'h1; reg_be = 4'hF;
      end else if (reg_req && ack6) begin
        reg_req = 1'b0; pend_apply = 1'b1; acks++;
      end
      if (i < 8) xl_drive(1'b1, 32'h8000_0000 | 32'($urandom_range(0, 32'hFFFF)));
      else xl_drive(1'b0, 32'h0);
    end
    reg_req = 1'b0;
    chk("stream_acks", 32'(acks), 32'd1);

    // Randomized configurations and translations
    for (int r = 0; r < 4; r++) begin
      for (int n = 0; n < 6; n++) begin
        a = 12'(12'h100 + 16 * n);
        reg_wr(12'(a + 4), $urandom, 4'(($urandom_range(0, 3) == 0) ? $urandom : 32'hF));
        reg_wr(12'(a + 8), ($urandom_range(0, 5) == 0) ? 32'h0 : (32'hFFFF_FFFF << $urandom_range(12, 31)), 4'hF);
        reg_wr(12'(a + 12), $urandom, 4'(($urandom_range(0, 3) == 0) ? $urandom : 32'hF));
        reg_wr(a, $urandom, 4'hF);
      end
      reg_rd(12'(12'h100 + 16 * $urandom_range(0, 5) + 4 * $urandom_range(0, 3)), rd);
      reg_wr(12'(12'h170 + 4 * $urandom_range(0, 35)), $urandom, 4'hF);
      for (int k = 0; k < 40; k++) begin
        int j;
        j = int'($urandom_range(0, 5));
        if ($urandom_range(0, 7) == 0) xl_cycle(1'b0, $urandom);
        else if ($urandom_range(0, 1) == 0) xl_cycle(1'b1, m_ba[j] ^ ($urandom & ~m_am[j]));
        else xl_cycle(1'b1, $urandom);
      end
      xl_cycle(1'b0, 32'h0);
    end
    xl_cycle(1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pci_image_xlat_regs.md
Name: pci_image_xlat_regs

Overview:
- Parametrised PCI-side image register file plus address-decode/translate pipeline; generalises the fixed six-image P_IMG_CTRLn/P_BAn_EXT/P_AMn/P_TAn map to NUM_IMG images with configurable mask granularity.
- Adds error-capture registers (P_ERR_CS/ADDR/DATA) with sticky overflow.
- Sits between the configuration-space slave and the PCI target datapath: software programs images over a register bus; the datapath presents incoming PCI addresses and receives hit/image/translated address one cycle later.

Parameters:
- NUM_IMG, 6, number of PCI images (1..6); image n occupies 12'h100 + 16*n.
- AM_LSB, 12, lowest mask/base/translation bit implemented; bits below read 0, writes ignored.
- ERR_BASE, 12'h160, offset of P_ERR_CS; P_ERR_ADDR at +4, P_ERR_DATA at +8.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_ni  in  1  asynchronous active-low reset.
- reg_req_i  in  1  register access request, held until reg_ack_o.
- reg_we_i  in  1  1=write, 0=read.
- reg_addr_i  in  12  byte address, bits [1:0] ignored.
- reg_wdata_i  in  32  write data.
- reg_be_i  in  4  byte enables for writes.
- reg_ack_o  out  1  one-cycle access completion.
- reg_err_o  out  1  asserted with reg_ack_o for unmapped address.
- reg_rdata_o  out  32  read data, valid with reg_ack_o.
- xl_valid_i  in  1  address to translate is valid.
- xl_addr_i  in  32  incoming PCI address.
- xl_valid_o  out  1  result valid (xl_valid_i delayed 1 cycle).
- xl_hit_o  out  1  some enabled image matched.
- xl_img_o  out  3  index of matching image.
- xl_addr_o  out  32  translated (or passed-through) address.
- err_log_i  in  1  datapath reports a transaction error.
- err_addr_i  in  32  failing address.
- err_data_i  in  32  failing data.
- err_pend_o  out  1  copy of P_ERR_CS.ERR_VALID.

Behaviour:
- Reset: all registers 0; reg_ack_o, reg_err_o, xl_valid_o, xl_hit_o, err_pend_o = 0; reg_rdata_o, xl_img_o, xl_addr_o = 0. Reset mid-access drops the access; no ack is generated.
- Register FSM: IDLE -> ACK on reg_req_i; ACK drives reg_ack_o=1 for exactly one cycle, then IDLE. A request held across ACK is not re-served in that cycle; the next request is accepted no earlier than the cycle after ack, so minimum spacing is 2 cycles.
- Writes commit on the ACK cycle, byte-merged per reg_be_i. New values are visible to translation from the cycle after ack.
- CTRL register: [0]=IMG_EN, [1]=AT_EN, [2]=PREF_EN; other bits read 0.
- BA/AM/TA: bits [31:AM_LSB] implemented, lower bits read 0.
- Image n >= NUM_IMG, or an unlisted offset: reads return 0, writes are ignored, reg_err_o=1 with the ack.
- Hit for image n: IMG_EN && AM != 0 && ((xl_addr_i ^ BA) & AM) == 0, over bits [31:AM_LSB].
- Multiple hits: lowest index wins.
- Translated address: AT_EN ? (xl_addr_i & ~AM) | (TA & AM) : xl_addr_i.
- Translation uses register values sampled in the xl_valid_i cycle, registered once: 1-cycle latency, full throughput.
- No hit: xl_hit_o=0, xl_img_o=0, xl_addr_o=xl_addr_i.
- When xl_valid_i=0: xl_valid_o=0 next cycle and the other outputs hold their previous value.
- P_ERR_CS: [0]=ERR_VALID (write-1-to-clear), [1]=ERR_OVF (sticky, write-1-to-clear); ERR_ADDR and ERR_DATA are read-only.
- err_log_i with ERR_VALID=0: capture address and data, set ERR_VALID.
- err_log_i with ERR_VALID=1: keep the old capture, set ERR_OVF.
- err_log_i in the same cycle as a W1C of ERR_VALID: the clear applies first, then the new error is captured, so ERR_VALID stays 1 with the new data.

Test Plan:
- After reset, read 12'h100..12'h15C and 12'h160..12'h168 -> all 0, each ack 1 cycle after req, reg_err_o=0.
- Write BA0=32'h8000_0FFF, AM0=32'hFFFF_0000, TA0=32'h1234_0000, CTRL0=3'b011; read back -> BA0=32'h8000_0000. Then xl_addr_i=32'h8000_ABCD -> next cycle hit=1, img=0, xl_addr_o=32'h1234_ABCD; with AT_EN=0 -> xl_addr_o=32'h8000_ABCD.
- Images 1 and 3 both match 32'hA000_0010 -> img=1. Disable image 1 -> img=3. Address 32'h0000_0010 -> hit=0, addr passes through.
- Set NUM_IMG=2; write 12'h120 -> reg_err_o=1, readback 0. Write 12'h170 -> reg_err_o=1.
- err_log_i with (32'hDEAD_0000, 32'h5A5A_5A5A) -> err_pend_o=1 and capture read back. Second err_log_i -> ERR_OVF=1, capture unchanged. W1C of 3 concurrent with a third error -> CS=1, new data captured.
- Back-to-back xl_valid_i for 8 cycles while CTRL0 is rewritten mid-stream -> results before the write-ack+1 cycle use the old values, later ones use the new values; no bubbles.
